// File: rtl/wb_sram_slave_if.sv
// Wishbone bus bundle between one interconnect slave port and wb_sram_slave.
// The master modport is the interconnect (or bench) side.
interface wb_sram_slave_if #(
   parameter int unsigned WB_ADDR_WIDTH = 32,
   parameter int unsigned WB_DATA_WIDTH = 32
);
   logic [WB_ADDR_WIDTH-1:0]   ADR;
   logic [WB_DATA_WIDTH-1:0]   DAT_W;
   logic [WB_DATA_WIDTH/8-1:0] SEL;
   logic                       CYC;
   logic                       STB;
   logic                       WE;
   logic [2:0]                 CTI;
   logic [1:0]                 BTE;
   logic [WB_DATA_WIDTH-1:0]   DAT_R;
   logic                       ACK;
   logic                       ERR;

   modport master (
      output ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
      input  DAT_R, ACK, ERR
   );

   modport slave (
      input  ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
      output DAT_R, ACK, ERR
   );
endinterface

// File: rtl/wb_sram_slave.sv
// On-chip SRAM Wishbone slave: classic cycles plus CTI/BTE incrementing bursts.
// Define WB_SRAM_ERR_EN to answer out-of-range accesses with ERR instead of aliasing.
module wb_sram_slave #(
   parameter int unsigned              WB_ADDR_WIDTH = 32,
   parameter int unsigned              WB_DATA_WIDTH = 32,
   parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
   parameter int unsigned              MEM_DEPTH     = 1024
) (
   input logic             clk,
   input logic             rst,
   wb_sram_slave_if.slave  wb
);
   localparam int unsigned BPW = WB_DATA_WIDTH / 8;
   localparam int unsigned LSB = $clog2(BPW);
   localparam int unsigned IW  = $clog2(MEM_DEPTH);
`ifdef WB_SRAM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_e;

   state_e                   state_q, state_d;
   logic                     ack_q, ack_d;
   logic                     err_q, err_d;
   logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
   logic [IW-1:0]            cnt_q, cnt_d;
   logic                     cnt_oor_q, cnt_oor_d;
   logic [1:0]               bte_q, bte_d;

   logic [WB_DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [WB_ADDR_WIDTH-1:0] off;
   logic [IW-1:0]            adr_idx;
   logic                     req, adr_oor, wr_en;

   assign off     = wb.ADR - BASE_ADDR;
   assign adr_idx = off[LSB +: IW];
   assign req     = wb.CYC & wb.STB;
   assign adr_oor = ERR_EN && ((wb.ADR < BASE_ADDR) ||
                    (64'(off) >= 64'(MEM_DEPTH) * 64'(BPW)));

   // Wrap modes only advance the low 2/3/4 index bits; linear rolls over MEM_DEPTH.
   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i, input logic [1:0] bte);
      case (bte)
         2'b01:   nxt = {i[IW-1:2], i[1:0] + 2'd1};
         2'b10:   nxt = {i[IW-1:3], i[2:0] + 3'd1};
         2'b11:   nxt = {i[IW-1:4], i[3:0] + 4'd1};
         default: nxt = i + IW'(1);
      endcase
   endfunction

   // Only a linear step off the top word can leave the in-range window.
   function automatic logic nxt_oor(input logic [IW-1:0] i, input logic [1:0] bte);
      nxt_oor = (bte == 2'b00) && (&i);
   endfunction

   always_comb begin
      state_d   = state_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      dat_d     = dat_q;
      cnt_d     = cnt_q;
      cnt_oor_d = cnt_oor_q;
      bte_d     = bte_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               bte_d = wb.BTE;
               if (adr_oor) begin
                  err_d   = 1'b1;
                  dat_d   = '0;
                  state_d = SINGLE;
               end else begin
                  ack_d     = 1'b1;
                  dat_d     = mem[adr_idx];
                  cnt_d     = nxt(adr_idx, wb.BTE);
                  cnt_oor_d = nxt_oor(adr_idx, wb.BTE);
                  state_d   = (wb.CTI == 3'b010) ? BURST : SINGLE;
               end
            end
         end
         SINGLE: state_d = IDLE;
         BURST: begin
            if (req && wb.CTI == 3'b010) begin
               if (ERR_EN && cnt_oor_q) begin
                  err_d   = 1'b1;
                  dat_d   = '0;
                  state_d = IDLE;
               end else begin
                  ack_d     = 1'b1;
                  dat_d     = mem[cnt_q];
                  cnt_d     = nxt(cnt_q, bte_q);
                  cnt_oor_d = nxt_oor(cnt_q, bte_q);
               end
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         dat_q     <= '0;
         cnt_q     <= '0;
         cnt_oor_q <= 1'b0;
         bte_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         dat_q     <= dat_d;
         cnt_q     <= cnt_d;
         cnt_oor_q <= cnt_oor_d;
         bte_q     <= bte_d;
      end
   end

   // A beat's write lands on the edge that completes its ACK, at the master's live address.
   assign wr_en = (state_q != IDLE) && ack_q && req && wb.WE;

   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         for (int b = 0; b < int'(BPW); b++) begin
            if (wb.SEL[b]) mem[adr_idx][b*8 +: 8] <= wb.DAT_W[b*8 +: 8];
         end
      end
   end

   assign wb.ACK   = ack_q;
   assign wb.ERR   = err_q;
   assign wb.DAT_R = dat_q;
endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave: expected beats are queued as they are driven
// and retired by a monitor on every strobed ACK/ERR.
module tb_wb_sram_slave;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int          MD   = 64;
`ifdef WB_SRAM_ERR_EN
   localparam bit ERRB = 1'b1;
`else
   localparam bit ERRB = 1'b0;
`endif

   typedef struct {
      logic [31:0] d;
      bit          cmp;
      bit          err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_sram_slave_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) wb ();

   wb_sram_slave #(
      .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .BASE_ADDR(BASE), .MEM_DEPTH(MD)
   ) dut (
      .clk(clk), .rst(rst), .wb(wb)
   );

   int          n_chk = 0;
   int          n_err = 0;
   exp_t        q[$];
   logic [31:0] mdl   [MD];
   bit          known [MD];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      logic [31:0] w;
      w = ((a - BASE) >> 2) % 32'(MD);
      return int'(w);
   endfunction

   function automatic bit oor(input logic [31:0] a);
      return (a < BASE) || ((a - BASE) >= 32'(MD * 4));
   endfunction

   task automatic bus_idle();
      wb.ADR = '0; wb.DAT_W = '0; wb.SEL = '0; wb.CYC = 1'b0;
      wb.STB = 1'b0; wb.WE = 1'b0; wb.CTI = 3'b000; wb.BTE = 2'b00;
   endtask

   task automatic wb_single(input logic [31:0] adr, input bit we,
                            input logic [31:0] dat, input logic [3:0] sel);
      int i;
      bit e;
      i = widx(adr);
      e = ERRB && oor(adr);
      q.push_back('{d: e ? 32'h0 : mdl[i], cmp: e || known[i], err: e});
      if (we && !e) begin
         for (int b = 0; b < 4; b++) if (sel[b]) mdl[i][b*8 +: 8] = dat[b*8 +: 8];
         if (sel == 4'hF) known[i] = 1'b1;
      end
      @(posedge clk); #1;
      wb.ADR = adr; wb.WE = we; wb.DAT_W = dat; wb.SEL = sel;
      wb.CTI = 3'b000; wb.BTE = 2'b00; wb.CYC = 1'b1; wb.STB = 1'b1;
      @(negedge clk); chk("no_comb_ack", wb.ACK, 0);
      @(negedge clk);
      if (e) begin
         chk("single_err", wb.ERR, 1);
         chk("err_no_ack", wb.ACK, 0);
      end else begin
         chk("single_ack", wb.ACK, 1);
      end
      @(posedge clk); #1 bus_idle();
      @(negedge clk); chk("single_end", {wb.ACK, wb.ERR}, 0);
   endtask

   // mode 0: CTI=111 on last beat; 1: master drops STB after n beats; 2: rst during last beat
   task automatic wb_burst(input int j0, input logic [1:0] bte, input int n, input bit we,
                           input logic [31:0] dbase, input int mode);
      int j, i, sz;
      bit e;
      j  = j0;
      sz = (bte == 2'b00) ? MD : (2 << bte);
      @(posedge clk); #1;
      for (int k = 0; k < n; k++) begin
         i = j % MD;
         e = ERRB && (j >= MD);
         wb.ADR = BASE + 32'(j * 4); wb.WE = we; wb.DAT_W = dbase + 32'(k); wb.SEL = 4'hF;
         wb.CTI = (k == n - 1 && mode == 0) ? 3'b111 : 3'b010;
         wb.BTE = bte; wb.CYC = 1'b1; wb.STB = 1'b1;
         q.push_back('{d: 32'h0, cmp: !e && known[i], err: e});
         q[$].d = e ? 32'h0 : mdl[i];
         if (we && !e && !(mode == 2 && k == n - 1)) begin
            mdl[i] = dbase + 32'(k);
            known[i] = 1'b1;
         end
         if (mode == 2 && k == n - 1) rst = 1'b1;
         if (k == 0) begin
            @(negedge clk); chk("burst_no_comb_ack", wb.ACK, 0);
         end
         @(negedge clk);
         if (e) chk("burst_err", wb.ERR, 1);
         else   chk("burst_ack", wb.ACK, 1);
         @(posedge clk); #1;
         if (e) break;
         if (bte == 2'b00) j = j + 1;
         else              j = (j & ~(sz - 1)) | ((j + 1) & (sz - 1));
      end
      rst = 1'b0;
      bus_idle();
      if (mode == 1) @(posedge clk);
      @(negedge clk); chk("burst_end", wb.ACK, 0);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (wb.CYC === 1'b1 && wb.STB === 1'b1 && (wb.ACK === 1'b1 || wb.ERR === 1'b1)) begin
         if (q.size() == 0) begin
            chk("sb_underflow", q.size(), 1);
         end else begin
            e = q.pop_front();
            chk("resp_err", wb.ERR, e.err);
            if (e.cmp) chk("rdata", wb.DAT_R, e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < MD; i++) begin mdl[i] = '0; known[i] = 1'b0; end
      bus_idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", wb.ACK, 0);
      chk("rst_err", wb.ERR, 0);
      chk("rst_dat", wb.DAT_R, 0);
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 16; i++) wb_single(BASE + 32'(i * 4), 1'b1, 32'h100 + 32'(i), 4'hF);
      wb_single(BASE + 32'((MD - 2) * 4), 1'b1, 32'hE0E0_0001, 4'hF);
      wb_single(BASE + 32'((MD - 1) * 4), 1'b1, 32'hE0E0_0002, 4'hF);

      // classic write/read and output hold
      wb_single(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
      wb_single(BASE + 32'h10, 1'b0, 32'h0, 4'hF);
      chk("dat_hold", wb.DAT_R, 32'hDEAD_BEEF);

      // byte lanes
      wb_single(BASE + 32'h20, 1'b1, 32'h0, 4'hF);
      wb_single(BASE + 32'h20, 1'b1, 32'h1122_3344, 4'b0101);
      wb_single(BASE + 32'h20, 1'b0, 32'h0, 4'hF);
      chk("byte_lanes", wb.DAT_R, 32'h0022_0044);

      // linear, wrap-4, wrap-8 write+read, wrap-16
      wb_burst(2, 2'b00, 4, 1'b0, 32'h0, 0);
      wb_burst(6, 2'b01, 4, 1'b0, 32'h0, 0);
      wb_burst(13, 2'b10, 5, 1'b1, 32'hA0, 0);
      wb_burst(13, 2'b10, 8, 1'b0, 32'h0, 0);
      wb_burst(14, 2'b11, 4, 1'b0, 32'h0, 0);

      // STB dropped mid-burst, then a fresh strobe at idx 8
      wb_burst(0, 2'b00, 2, 1'b0, 32'h0, 1);
      wb_single(BASE + 32'h20, 1'b0, 32'h0, 4'hF);

      // reset during the third write beat; that beat must not land
      wb_burst(10, 2'b00, 3, 1'b1, 32'hC0, 2);
      wb_burst(10, 2'b00, 4, 1'b0, 32'h0, 0);

      // top of range: linear burst crossing MEM_DEPTH, then out-of-range singles
      wb_burst(MD - 2, 2'b00, 3, 1'b0, 32'h0, 0);
      wb_single(BASE + 32'(MD * 4), 1'b0, 32'h0, 4'hF);
      wb_single(BASE + 32'(MD * 4), 1'b1, 32'h5555_AAAA, 4'hF);
      wb_single(BASE, 1'b0, 32'h0, 4'hF);
      wb_single(BASE - 32'h4, 1'b0, 32'h0, 4'hF);

      repeat (2) @(posedge clk);
      chk("sb_left", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
